mvu_dma_sched: RTL and testbench

Descriptor queue and sequencer in front of the MVU DMA core. Software or a host agent pushes transfer descriptors (source address, destination address, size, role, irq flag) into a small FIFO. The block then issues them one at a time to the DMA core's configuration/start inputs and tracks completion through the core's status word. It raises a sticky interrupt on flagged completions and on errors, so a whole layer's data and weight loads run without per-transfer CPU involvement.

---
 rtl/mvu_dma_pkg.sv | 25 ++
 rtl/mvu_dma_desc_fifo.sv | 63 ++++++
 rtl/mvu_dma_sched.sv | 209 ++++++++++++++++++++
 tb/tb_mvu_dma_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_dma_pkg.sv
// Shared types for the MVU DMA descriptor scheduler: descriptor layout, FSM
// encoding and DMA core status bit positions.
package mvu_dma_pkg;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] size;
    logic        role;
    logic        irq;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;

endpackage

// File: rtl/mvu_dma_desc_fifo.sv
// Descriptor FIFO: DEPTH entries (power of 2), synchronous push/pop, flush
// empties the queue in one cycle and overrides any push or pop.
module mvu_dma_desc_fifo
  import mvu_dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  desc_t                    i_data,
  output desc_t                    o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  desc_t           r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/mvu_dma_sched.sv
// Descriptor queue + sequencer driving the MVU DMA core one transfer at a time.
// Optional watchdog per transfer: define MVU_DMA_SCHED_TIMEOUT_EN.
module mvu_dma_sched
  import mvu_dma_pkg::*;
#(
  parameter int          DEPTH          = 4,
  parameter int          CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    flush_i,
  input  logic                    desc_valid_i,
  output logic                    desc_ready_o,
  input  logic [31:0]             desc_src_i,
  input  logic [31:0]             desc_dst_i,
  input  logic [15:0]             desc_size_i,
  input  logic                    desc_role_i,
  input  logic                    desc_irq_i,
  output logic [31:0]             dma_source_addr_o,
  output logic [31:0]             dma_dest_addr_o,
  output logic [15:0]             dma_transfer_size_o,
  output logic                    dma_transfer_role_o,
  output logic                    dma_start_o,
  input  logic [31:0]             dma_status_i,
  output logic                    irq_o,
  input  logic                    irq_clr_i,
  output logic                    err_o,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic [CNT_W-1:0]        done_cnt_o
);

  desc_t      w_in_desc;
  desc_t      w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_flush;
  logic       w_err_flush;
  logic       w_load;
  logic       w_done;
  logic       w_irq_set;
  logic       w_err_set;
  logic       w_timeout;
  logic       w_unused;

  state_t     r_state;
  state_t     w_state_next;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [15:0] r_size;
  logic        r_role;
  logic        r_cur_irq;
  logic        r_irq;
  logic        r_err;
  logic [CNT_W-1:0] r_done_cnt;

  assign w_unused  = ^dma_status_i[31:2];
  assign w_in_desc = '{src: desc_src_i, dst: desc_dst_i, size: desc_size_i,
                       role: desc_role_i, irq: desc_irq_i};

  // Internal error flush also drops ready so a handshake is never silently lost.
  assign w_flush      = flush_i | w_err_flush;
  assign desc_ready_o = ~w_full & ~w_flush;
  assign w_push       = desc_valid_i & desc_ready_o;
  assign w_pop        = (r_state == S_IDLE) & enable_i & ~w_empty & ~flush_i;

  mvu_dma_desc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_in_desc),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );

`ifdef MVU_DMA_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  logic [31:0] w_unused_to;
  assign w_unused_to = TIMEOUT_CYCLES;
  assign w_timeout   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_done       = 1'b0;
    w_irq_set    = 1'b0;
    w_err_set    = 1'b0;
    w_err_flush  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          // Zero-size entries complete in place without touching the core.
          if (w_head.size == '0) begin
            w_done    = 1'b1;
            w_irq_set = w_head.irq;
          end else begin
            w_load       = 1'b1;
            w_state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_timeout) begin
          w_state_next = S_IDLE;
          w_err_set    = 1'b1;
          w_irq_set    = 1'b1;
          w_err_flush  = 1'b1;
        end else if (dma_status_i[STAT_BUSY]) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!dma_status_i[STAT_BUSY]) begin
          w_state_next = S_IDLE;
          w_done       = 1'b1;
          if (dma_status_i[STAT_ERR]) begin
            w_err_set   = 1'b1;
            w_irq_set   = 1'b1;
            w_err_flush = 1'b1;
          end else begin
            w_irq_set = r_cur_irq;
          end
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
          w_err_set    = 1'b1;
          w_irq_set    = 1'b1;
          w_err_flush  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_size    <= '0;
      r_role    <= 1'b0;
      r_cur_irq <= 1'b0;
    end else if (w_load) begin
      r_src     <= w_head.src;
      r_dst     <= w_head.dst;
      r_size    <= w_head.size;
      r_role    <= w_head.role;
      r_cur_irq <= w_head.irq;
    end
  end

  // Sticky flags: a set condition beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq      <= 1'b0;
      r_err      <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      if (w_irq_set)      r_irq <= 1'b1;
      else if (irq_clr_i) r_irq <= 1'b0;
      if (w_err_set)      r_err <= 1'b1;
      else if (irq_clr_i) r_err <= 1'b0;
      if (w_done)         r_done_cnt <= r_done_cnt + CNT_W'(1);
    end
  end

  assign dma_source_addr_o   = r_src;
  assign dma_dest_addr_o     = r_dst;
  assign dma_transfer_size_o = r_size;
  assign dma_transfer_role_o = r_role;
  assign dma_start_o         = (r_state == S_ISSUE);
  assign irq_o               = r_irq;
  assign err_o               = r_err;
  assign busy_o              = (r_state != S_IDLE) | ~w_empty;
  assign done_cnt_o          = r_done_cnt;

endmodule

// File: tb/tb_mvu_dma_sched.sv
// Directed bench for mvu_dma_sched with a simple DMA core responder model.
module tb_mvu_dma_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        flush_i;
  logic        desc_valid_i;
  logic        desc_ready_o;
  logic [31:0] desc_src_i;
  logic [31:0] desc_dst_i;
  logic [15:0] desc_size_i;
  logic        desc_role_i;
  logic        desc_irq_i;
  logic [31:0] dma_source_addr_o;
  logic [31:0] dma_dest_addr_o;
  logic [15:0] dma_transfer_size_o;
  logic        dma_transfer_role_o;
  logic        dma_start_o;
  logic [31:0] dma_status_i;
  logic        irq_o;
  logic        irq_clr_i;
  logic        err_o;
  logic        busy_o;
  logic [2:0]  level_o;
  logic [15:0] done_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_done = 0;

  always #5 clk = ~clk;

  mvu_dma_sched #(
    .DEPTH          (4),
    .CNT_W          (16),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable_i            (enable_i),
    .flush_i             (flush_i),
    .desc_valid_i        (desc_valid_i),
    .desc_ready_o        (desc_ready_o),
    .desc_src_i          (desc_src_i),
    .desc_dst_i          (desc_dst_i),
    .desc_size_i         (desc_size_i),
    .desc_role_i         (desc_role_i),
    .desc_irq_i          (desc_irq_i),
    .dma_source_addr_o   (dma_source_addr_o),
    .dma_dest_addr_o     (dma_dest_addr_o),
    .dma_transfer_size_o (dma_transfer_size_o),
    .dma_transfer_role_o (dma_transfer_role_o),
    .dma_start_o         (dma_start_o),
    .dma_status_i        (dma_status_i),
    .irq_o               (irq_o),
    .irq_clr_i           (irq_clr_i),
    .err_o               (err_o),
    .busy_o              (busy_o),
    .level_o             (level_o),
    .done_cnt_o          (done_cnt_o)
  );

  // DMA core model: busy for 5 cycles after each start, optional error/hang.
  int          busy_cnt;
  logic        cur_err;
  int          n_starts = 0;
  int          err_idx  = -1;
  bit          hang     = 1'b0;
  int          cyc      = 0;
  int          last_start_cyc = 0;
  logic [31:0] st_src[$];
  logic [31:0] st_dst[$];
  logic [15:0] st_size[$];
  logic        st_role[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 0;
      cur_err  <= 1'b0;
    end else begin
      cyc++;
      if (dma_start_o) begin
        busy_cnt <= 5;
        cur_err  <= (n_starts == err_idx);
        st_src.push_back(dma_source_addr_o);
        st_dst.push_back(dma_dest_addr_o);
        st_size.push_back(dma_transfer_size_o);
        st_role.push_back(dma_transfer_role_o);
        n_starts++;
        last_start_cyc = cyc;
      end else if (busy_cnt > 0 && !hang) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  assign dma_status_i = {30'b0, cur_err && (busy_cnt == 0), busy_cnt != 0};

  task automatic clear_log();
    st_src.delete();
    st_dst.delete();
    st_size.delete();
    st_role.delete();
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [15:0] sz,
                      input logic r, input logic q, output logic acc);
    desc_src_i   = s;
    desc_dst_i   = d;
    desc_size_i  = sz;
    desc_role_i  = r;
    desc_irq_i   = q;
    desc_valid_i = 1'b1;
    #1;
    acc = desc_ready_o;
    @(negedge clk);
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy_o) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (desc_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", desc_ready_o); end
    n_cmp++;
    if (level_o !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level_o); end
    n_cmp++;
    if ({irq_o, err_o, busy_o, dma_start_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got irq%b err%b busy%b start%b want 0", irq_o, err_o, busy_o, dma_start_o);
    end
    n_cmp++;
    if (done_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_done got %0d want 0", done_cnt_o); end
    $display("reset: ready=%b level=%0d done=%0d", desc_ready_o, level_o, done_cnt_o);
  endtask

  task automatic test_basic();
    logic [31:0] e_src  [3] = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200};
    logic [31:0] e_dst  [3] = '{32'h2000_0000, 32'h2000_0100, 32'h2000_0200};
    logic [15:0] e_size [3] = '{16'd8, 16'd16, 16'd4};
    logic        e_role [3] = '{1'b0, 1'b1, 1'b0};
    logic        e_irq  [3] = '{1'b0, 1'b0, 1'b1};
    logic acc;
    bit   early = 1'b0;
    bit   to    = 1'b1;
    clear_log();
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) push(e_src[i], e_dst[i], e_size[i], e_role[i], e_irq[i], acc);
    n_cmp++;
    if (level_o !== 3'd3) begin n_fail++; $display("FAIL basic_level got %0d want 3", level_o); end
    enable_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_cnt_o < 16'(exp_done + 3) && irq_o) early = 1'b1;
      if (!busy_o) begin to = 1'b0; break; end
    end
    exp_done += 3;
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL basic_timeout got busy=%b want 0", busy_o); end
    n_cmp++;
    if (st_size.size() !== 3) begin n_fail++; $display("FAIL basic_starts got %0d want 3", st_size.size()); end
    for (int i = 0; i < 3 && i < st_size.size(); i++) begin
      n_cmp++;
      if (st_src[i] !== e_src[i] || st_dst[i] !== e_dst[i] || st_size[i] !== e_size[i] || st_role[i] !== e_role[i]) begin
        n_fail++;
        $display("FAIL basic_cfg%0d got %h/%h/%0d/%b want %h/%h/%0d/%b", i, st_src[i], st_dst[i], st_size[i], st_role[i],
                 e_src[i], e_dst[i], e_size[i], e_role[i]);
      end
    end
    n_cmp++;
    if (done_cnt_o !== 16'(exp_done)) begin n_fail++; $display("FAIL basic_done got %0d want %0d", done_cnt_o, exp_done); end
    n_cmp++;
    if (irq_o !== 1'b1 || early) begin n_fail++; $display("FAIL basic_irq got irq=%b early=%b want 1/0", irq_o, early); end
    irq_clr_i = 1'b1;
    @(negedge clk);
    irq_clr_i = 1'b0;
    n_cmp++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL basic_irq_clr got %b want 0", irq_o); end
    $display("basic: starts=%0d done=%0d", st_size.size(), done_cnt_o);
  endtask

  task automatic test_full();
    logic [15:0] e_size [4] = '{16'd3, 16'd5, 16'd7, 16'd9};
    logic acc;
    bit   to;
    clear_log();
    enable_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), e_size[i], 1'b1, 1'b0, acc);
    n_cmp++;
    if (level_o !== 3'd4 || desc_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full_level got %0d/%b want 4/0", level_o, desc_ready_o);
    end
    push(32'hDEAD_0000, 32'hDEAD_0001, 16'd99, 1'b0, 1'b0, acc);
    n_cmp++;
    if (acc !== 1'b0 || level_o !== 3'd4) begin
      n_fail++; $display("FAIL full_fifth got acc=%b level=%0d want 0/4", acc, level_o);
    end
    enable_i = 1'b1;
    wait_idle(300, to);
    exp_done += 4;
    n_cmp++;
    if (to || st_size.size() !== 4) begin n_fail++; $display("FAIL full_starts got %0d to=%b want 4", st_size.size(), to); end
    for (int i = 0; i < 4 && i < st_size.size(); i++) begin
      n_cmp++;
      if (st_size[i] !== e_size[i] || st_src[i] !== 32'hA000_0000 + 32'(i)) begin
        n_fail++; $display("FAIL full_order%0d got %0d/%h want %0d/%h", i, st_size[i], st_src[i], e_size[i], 32'hA000_0000 + 32'(i));
      end
    end
    n_cmp++;
    if (done_cnt_o !== 16'(exp_done)) begin n_fail++; $display("FAIL full_done got %0d want %0d", done_cnt_o, exp_done); end
    $display("full: starts=%0d done=%0d", st_size.size(), done_cnt_o);
  endtask

  task automatic test_zero_size();
    logic acc;
    bit   to;
    clear_log();
    enable_i = 1'b0;
    push(32'h3000_0000, 32'h4000_0000, 16'd0,  1'b0, 1'b0, acc);
    push(32'h3000_0010, 32'h4000_0010, 16'd12, 1'b0, 1'b0, acc);
    push(32'h3000_0020, 32'h4000_0020, 16'd0,  1'b0, 1'b0, acc);
    enable_i = 1'b1;
    wait_idle(100, to);
    exp_done += 3;
    n_cmp++;
    if (to || st_size.size() !== 1) begin n_fail++; $display("FAIL zero_starts got %0d to=%b want 1", st_size.size(), to); end
    if (st_size.size() > 0) begin
      n_cmp++;
      if (st_size[0] !== 16'd12 || st_src[0] !== 32'h3000_0010) begin
        n_fail++; $display("FAIL zero_cfg got %0d/%h want 12/30000010", st_size[0], st_src[0]);
      end
    end
    n_cmp++;
    if (done_cnt_o !== 16'(exp_done) || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL zero_done got %0d irq=%b want %0d/0", done_cnt_o, irq_o, exp_done);
    end
    $display("zero: starts=%0d done=%0d", st_size.size(), done_cnt_o);
  endtask

  task automatic test_error();
    logic acc;
    bit   to;
    clear_log();
    enable_i = 1'b0;
    err_idx  = n_starts;
    for (int i = 0; i < 3; i++) push(32'h5000_0000 + 32'(i), 32'h6000_0000, 16'd4, 1'b0, 1'b0, acc);
    enable_i = 1'b1;
    wait_idle(100, to);
    exp_done += 1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (to || err_o !== 1'b1 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL err_flags got err=%b irq=%b to=%b want 1/1/0", err_o, irq_o, to);
    end
    n_cmp++;
    if (level_o !== 3'd0 || st_size.size() !== 1) begin
      n_fail++; $display("FAIL err_flush got level=%0d starts=%0d want 0/1", level_o, st_size.size());
    end
    n_cmp++;
    if (done_cnt_o !== 16'(exp_done)) begin n_fail++; $display("FAIL err_done got %0d want %0d", done_cnt_o, exp_done); end
    irq_clr_i = 1'b1;
    @(negedge clk);
    irq_clr_i = 1'b0;
    err_idx   = -1;
    n_cmp++;
    if (err_o !== 1'b0 || irq_o !== 1'b0) begin n_fail++; $display("FAIL err_clr got err=%b irq=%b want 0/0", err_o, irq_o); end
    $display("error: err cleared, starts=%0d done=%0d", st_size.size(), done_cnt_o);
  endtask

  task automatic test_flush();
    logic acc;
    bit   to;
    clear_log();
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h7000_0000 + 32'(i), 32'h8000_0000, 16'd6, 1'b0, 1'b0, acc);
    enable_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b0;
    n_cmp++;
    if (level_o !== 3'd2) begin n_fail++; $display("FAIL flush_pre_level got %0d want 2", level_o); end
    repeat (2) @(negedge clk);
    flush_i      = 1'b1;
    desc_valid_i = 1'b1;
    #1;
    n_cmp++;
    if (desc_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", desc_ready_o); end
    @(negedge clk);
    flush_i      = 1'b0;
    desc_valid_i = 1'b0;
    n_cmp++;
    if (level_o !== 3'd0) begin n_fail++; $display("FAIL flush_level got %0d want 0", level_o); end
    enable_i = 1'b1;
    wait_idle(100, to);
    exp_done += 1;
    n_cmp++;
    if (to || done_cnt_o !== 16'(exp_done) || st_size.size() !== 1) begin
      n_fail++; $display("FAIL flush_done got %0d starts=%0d want %0d/1", done_cnt_o, st_size.size(), exp_done);
    end
    $display("flush: level=%0d done=%0d", level_o, done_cnt_o);
  endtask

`ifdef MVU_DMA_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic acc;
    int   err_cyc = -1;
    clear_log();
    hang     = 1'b1;
    enable_i = 1'b1;
    push(32'h9000_0000, 32'h9100_0000, 16'd4, 1'b0, 1'b0, acc);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (err_o) begin err_cyc = cyc; break; end
    end
    n_cmp++;
    if (err_cyc - last_start_cyc !== 10) begin
      n_fail++; $display("FAIL timeout_cycle got %0d want 10", err_cyc - last_start_cyc);
    end
    n_cmp++;
    if (busy_o !== 1'b0 || irq_o !== 1'b1 || done_cnt_o !== 16'(exp_done)) begin
      n_fail++; $display("FAIL timeout_state got busy=%b irq=%b done=%0d want 0/1/%0d", busy_o, irq_o, done_cnt_o, exp_done);
    end
    hang = 1'b0;
    $display("timeout: err after %0d cycles", err_cyc - last_start_cyc);
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    enable_i     = 1'b0;
    flush_i      = 1'b0;
    desc_valid_i = 1'b0;
    desc_src_i   = '0;
    desc_dst_i   = '0;
    desc_size_i  = '0;
    desc_role_i  = 1'b0;
    desc_irq_i   = 1'b0;
    irq_clr_i    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_zero_size();
    test_error();
    test_flush();
`ifdef MVU_DMA_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
